// File: rtl/chad_stack_pkg.sv
// Shared encodings, defaults and sizing helper for the chad data/return stacks.
package chad_stack_pkg;

    localparam logic [1:0]  DELTA_NONE   = 2'b00;
    localparam logic [1:0]  DELTA_UP     = 2'b01;
    // Any delta with bit 1 set pops; DELTA_DN carries that bit as a mask.
    localparam logic [1:0]  DELTA_DN     = 2'b10;

    localparam logic [31:0] FILL_DEFAULT = 32'h55AA55AA;

    // Counter width able to hold 0..DEPTH+1 (tail plus registered head).
    function automatic int cw_of(input int depth);
        return $clog2(depth + 2);
    endfunction

    function automatic logic is_pop(input logic [1:0] d);
        return (d & DELTA_DN) != 2'b00;
    endfunction

endpackage

// File: rtl/stack_tracked_level.sv
// Occupancy counter, full/empty decode and sticky ovf/unf flags for stack_tracked.
// STACK_SAT_EN: drives suppress on push-while-full / pop-while-empty.
module stack_level
    import chad_stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = cw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf,
    output logic          suppress
);

    localparam logic [CW-1:0] CAP_C = CW'(DEPTH + 1);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          full_w, empty_w;

    assign full_w  = (count_q == CAP_C);
    assign empty_w = (count_q == '0);

`ifdef STACK_SAT_EN
    assign suppress = (push && full_w) || (pop && empty_w);
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        if (push && !full_w) begin
            count_d = count_q + 1'b1;
        end else if (pop && !empty_w) begin
            count_d = count_q - 1'b1;
        end
    end

    // A fresh error in the same cycle as clr_err keeps its flag set.
    always_comb begin
        ovf_d = (ovf_q && !clr_err) || (push && full_w);
        unf_d = (unf_q && !clr_err) || (pop && empty_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign full  = full_w;
    assign empty = empty_w;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: rtl/stack_tracked.sv
// Shift-register stack: registered TOS + DEPTH-cell tail, NOS port, occupancy and sticky errors.
// Optional STACK_SAT_EN: boundary push/pop leave data untouched instead of wrapping.
module stack_tracked
    import chad_stack_pkg::*;
#(
    parameter int          WIDTH = 18,
    parameter int          DEPTH = 16,
    parameter logic [31:0] FILL  = FILL_DEFAULT,
    localparam int         CW    = cw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             we,
    input  logic [1:0]       delta,
    input  logic [WIDTH-1:0] wd,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] rd2,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] FILL_W = FILL[WIDTH-1:0];

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q [DEPTH];
    logic [WIDTH-1:0] tail_d [DEPTH];

    logic push_req, pop_req, suppress;

    assign push_req = !hold && (delta == DELTA_UP);
    assign pop_req  = !hold && is_pop(delta);

    stack_level #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_level (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .pop      (pop_req),
        .clr_err  (clr_err && !hold),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .unf      (unf),
        .suppress (suppress)
    );

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (!hold && !suppress) begin
            if (push_req) begin
                tail_d[0] = head_q;
                for (int i = 1; i < DEPTH; i++) begin
                    tail_d[i] = tail_q[i-1];
                end
                head_d = we ? wd : head_q;
            end else if (pop_req) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    tail_d[i] = tail_q[i+1];
                end
                tail_d[DEPTH-1] = FILL_W;
                head_d = we ? wd : tail_q[0];
            end else if (we) begin
                head_d = wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tail_q[i] <= FILL_W;
            end
        end else begin
            head_q <= head_d;
            for (int i = 0; i < DEPTH; i++) begin
                tail_q[i] <= tail_d[i];
            end
        end
    end

    assign rd  = head_q;
    assign rd2 = tail_q[0];

endmodule

// File: tb/tb_stack_tracked.sv
// Directed bench for stack_tracked (WIDTH=18, DEPTH=16); follows STACK_SAT_EN like the RTL.
module tb_stack_tracked;

    localparam int W = 18;
`ifdef STACK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, hold, we, clr_err;
    logic [1:0]   delta;
    logic [W-1:0] wd;
    logic [W-1:0] rd, rd2;
    logic [4:0]   count;
    logic         full, empty, ovf, unf;

    always #5 clk = ~clk;

    stack_tracked #(.WIDTH(W), .DEPTH(16), .FILL(32'h55AA55AA)) dut (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .we      (we),
        .delta   (delta),
        .wd      (wd),
        .clr_err (clr_err),
        .rd      (rd),
        .rd2     (rd2),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .unf     (unf)
    );

    typedef struct {
        logic         r, h, w;
        logic [1:0]   d;
        logic [W-1:0] x;
        logic         c;
        logic [W-1:0] e_rd, e_rd2;
        logic [4:0]   e_cnt;
        logic         e_full, e_empty, e_ovf, e_unf;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0]  fill32;
    logic [W-1:0] fv;
    vec_t         vq[$];

    function automatic vec_t mk(input logic r, h, w, input logic [1:0] d, input logic [W-1:0] x,
                                input logic c, input logic [W-1:0] erd, erd2, input logic [4:0] ec,
                                input logic ef, ee, eo, eu);
        vec_t v;
        v.r = r; v.h = h; v.w = w; v.d = d; v.x = x; v.c = c;
        v.e_rd = erd; v.e_rd2 = erd2; v.e_cnt = ec;
        v.e_full = ef; v.e_empty = ee; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic drive(input logic r, h, w, input logic [1:0] d, input logic [W-1:0] x, input logic c);
        rst = r; hold = h; we = w; delta = d; wd = x; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [W-1:0] erd, erd2,
                         input logic [4:0] ec, input logic ef, ee, eo, eu);
        checks++;
        if ({rd, rd2, count, full, empty, ovf, unf} !== {erd, erd2, ec, ef, ee, eo, eu}) begin
            errors++;
            $display("FAIL %s[%0d]: got rd=%h rd2=%h count=%0d full=%b empty=%b ovf=%b unf=%b; want rd=%h rd2=%h count=%0d full=%b empty=%b ovf=%b unf=%b",
                     nm, idx, rd, rd2, count, full, empty, ovf, unf, erd, erd2, ec, ef, ee, eo, eu);
        end
    endtask

    initial begin
        int top;
        fill32 = 32'h55AA55AA;
        fv     = fill32[W-1:0];

        // Reset with hold asserted must still reset.
        drive(1, 1, 1, 2'b01, 18'h1234, 1);
        drive(1, 1, 0, 2'b00, 18'h0, 0);
        check("reset", 0, 18'h0, fv, 5'd0, 0, 1, 0, 0);

        for (int k = 1; k <= 17; k++) begin
            drive(0, 0, 1, 2'b01, W'(k), 0);
            check("push", k, W'(k), W'(k - 1), 5'(k), k == 17, 0, 0, 0);
        end

        // Push while full: flag sets, count saturates; data depends on mode.
        drive(0, 0, 1, 2'b01, 18'h3FFFF, 0);
        check("ovf", 0, SAT ? 18'd17 : 18'h3FFFF, SAT ? 18'd16 : 18'd17, 5'd17, 1, 0, 1, 0);
        drive(0, 0, 0, 2'b00, 18'h0, 1);
        check("ovf_clr", 0, SAT ? 18'd17 : 18'h3FFFF, SAT ? 18'd16 : 18'd17, 5'd17, 1, 0, 0, 0);

        // Wrap mode lost the bottom value 1, so everything sits one higher.
        top = SAT ? 17 : 18;
        for (int j = 1; j <= 17; j++) begin
            drive(0, 0, 0, (j % 2) ? 2'b10 : 2'b11, 18'h0, 0);
            check("pop", j, (j == 17) ? fv : W'(top - j), (j <= 15) ? W'(top - 1 - j) : fv,
                  5'(17 - j), 0, j == 17, 0, 0);
        end

        //        r  h  w  d      wd        c   rd                    rd2       cnt f  e  o  u
        vq.push_back(mk(0, 0, 0, 2'b10, 18'h0,    0, fv,                   fv,      0, 0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 2'b10, 18'h0,    1, fv,                   fv,      0, 0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 2'b00, 18'h0,    1, fv,                   fv,      0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b01, 18'h9,    0, 18'h9,                fv,      1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b01, 18'h7,    0, 18'h7,                18'h9,   2, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b01, 18'h5,    0, 18'h5,                18'h7,   3, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 2'b01, 18'h123,  0, 18'h5,                18'h7,   3, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b10, 18'hA,    0, 18'hA,                18'h9,   2, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b00, 18'h2222, 0, 18'h2222,             18'h9,   2, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 2'b00, 18'h3333, 0, 18'h2222,             18'h9,   2, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 2'b11, 18'h0,    0, 18'h9,                fv,      1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 2'b10, 18'h0,    0, fv,                   fv,      0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 2'b10, 18'h0,    0, fv,                   fv,      0, 0, 1, 0, 1));
        vq.push_back(mk(0, 1, 0, 2'b00, 18'h0,    1, fv,                   fv,      0, 0, 1, 0, 1));
        vq.push_back(mk(1, 1, 1, 2'b01, 18'h77,   0, 18'h0,                fv,      0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b10, 18'h1111, 0, SAT ? 18'h0 : 18'h1111, fv,    0, 0, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 2'b00, 18'h0,    0, 18'h0,                fv,      0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 2'b01, 18'h0,    0, 18'h0,                18'h0,   1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 2'b01, 18'h3,    1, 18'h3,                18'h0,   2, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 2'b01, 18'h4,    0, 18'h0,                fv,      0, 0, 1, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].r, vq[i].h, vq[i].w, vq[i].d, vq[i].x, vq[i].c);
            check("vec", i, vq[i].e_rd, vq[i].e_rd2, vq[i].e_cnt,
                  vq[i].e_full, vq[i].e_empty, vq[i].e_ovf, vq[i].e_unf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
